// File: rtl/jkscan_defs.sv
// jkscan_defs: state encodings and default chain length shared by the scan controller
package jkscan_defs;
  localparam int N_DEF = 8;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CAPT = 3'd2,
    S_UNLD = 3'd3,
    S_FIN  = 3'd4
  } state_t;
endpackage

// File: rtl/jkscan_shreg.sv
// jkscan_shreg: serialises the latched pattern MSB-first and deserialises SO into CAPT
module jkscan_shreg #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         adv,
  input  logic         clr,
  input  logic         cap,
  input  logic [N-1:0] pat,
  input  logic         so,
  output logic         si,
  output logic [N-1:0] capt,
  output logic [N-1:0] capt_nxt
);
  logic [N-1:0] sr;
  // the first unloaded bit ends up in the MSB after N shifts
  assign capt_nxt = {capt[N-2:0], so};
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr   <= '0;
      si   <= 1'b0;
      capt <= '0;
    end else begin
      if (load) begin
        sr   <= {pat[N-2:0], 1'b0};
        si   <= pat[N-1];
        capt <= '0;
      end else if (adv) begin
        sr <= {sr[N-2:0], 1'b0};
        si <= sr[N-1];
      end else if (clr) begin
        si <= 1'b0;
      end
      if (cap) capt <= capt_nxt;
    end
  end
endmodule

// File: rtl/jkscan_ctl.sv
// jkscan_ctl: scan-test sequencer that loads, captures and unloads the JK datapath register
module jkscan_ctl
  import jkscan_defs::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] PATTERN,
  input  logic [N-1:0] EXPECT,
  input  logic [N-1:0] MASK,
  input  logic         SO,
  output logic         TEST,
  output logic         SCANIN,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] CAPT,
  output logic         MISMATCH
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     exp_r, mask_r, capt_nxt;
  logic             last, load;
  assign last = cnt == CNT_W'(N - 1);
  assign load = state == S_IDLE && START;
  jkscan_shreg #(.N(N)) u_shreg (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .adv      (state == S_LOAD && !last),
    .clr      (state == S_LOAD && last),
    .cap      (state == S_UNLD),
    .pat      (PATTERN),
    .so       (SO),
    .si       (SCANIN),
    .capt     (CAPT),
    .capt_nxt (capt_nxt)
  );
  // outputs are set on the edge entering each state so they are valid for its whole cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      exp_r    <= '0;
      mask_r   <= '0;
      TEST     <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      MISMATCH <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          TEST <= 1'b0;
          if (START) begin
            state    <= S_LOAD;
            cnt      <= '0;
            exp_r    <= EXPECT;
            mask_r   <= MASK;
            MISMATCH <= 1'b0;
            BUSY     <= 1'b1;
            TEST     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (last) begin
            state <= S_CAPT;
            TEST  <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
        end
        S_CAPT: begin
          state <= S_UNLD;
          cnt   <= '0;
          TEST  <= 1'b1;
        end
        S_UNLD: begin
          if (last) begin
            state    <= S_FIN;
            TEST     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            MISMATCH <= |((capt_nxt ^ exp_r) & mask_r);
          end else cnt <= cnt + CNT_W'(1);
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jkscan_ctl.sv
// tb_jkscan_ctl: drives two controllers against JK chain models and scoreboards their results
module tb_jkscan_ctl;
  typedef struct packed {
    logic [7:0] capt;
    logic       mism;
  } exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  logic       start8 = 1'b0;
  logic [7:0] pat8 = '0, exp8 = '0, mask8 = '0;
  logic [7:0] q8 = '0, j8 = '0, k8 = '0;
  logic       test8, si8, busy8, done8, mism8;
  logic [7:0] capt8;
  logic       start2 = 1'b0;
  logic [1:0] pat2 = '0, exp2 = '0, mask2 = '0;
  logic [1:0] q2 = '0, j2 = '0, k2 = '0;
  logic       test2, si2, busy2, done2, mism2;
  logic [1:0] capt2;
  always @(posedge CLK) q8 <= test8 ? {q8[6:0], si8} : (j8 & ~q8) | (~k8 & q8);
  always @(posedge CLK) q2 <= test2 ? {q2[0], si2} : (j2 & ~q2) | (~k2 & q2);
  jkscan_ctl #(.N(8), .CNT_W(8)) dut8 (
    .CLK(CLK), .RST(RST), .START(start8), .PATTERN(pat8), .EXPECT(exp8), .MASK(mask8),
    .SO(q8[7]), .TEST(test8), .SCANIN(si8), .BUSY(busy8), .DONE(done8), .CAPT(capt8),
    .MISMATCH(mism8)
  );
  jkscan_ctl #(.N(2), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .START(start2), .PATTERN(pat2), .EXPECT(exp2), .MASK(mask2),
    .SO(q2[1]), .TEST(test2), .SCANIN(si2), .BUSY(busy2), .DONE(done2), .CAPT(capt2),
    .MISMATCH(mism2)
  );
  task automatic start_8(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m);
    logic [7:0] c;
    c = (j8 & ~p) | (~k8 & p);
    pat8 = p; exp8 = e; mask8 = m; start8 = 1'b1;
    sbq.push_back('{capt: c, mism: |((c ^ e) & m)});
    @(negedge CLK);
    start8 = 1'b0;
  endtask
  task automatic wait_done8(output int ed);
    exp_t e;
    ed = 0;
    while (!done8 && ed < 200) begin
      @(negedge CLK);
      ed++;
    end
    total++;
    if (!done8) begin
      bad++;
      $display("FAIL done8_timeout: no DONE after %0d cycles", ed);
    end else if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: DONE with no expected entry, capt=%h", capt8);
    end else begin
      e = sbq.pop_front();
      if (capt8 !== e.capt || mism8 !== e.mism || busy8 !== 1'b0) begin
        bad++;
        $display("FAIL result8: capt=%h mism=%b busy=%b want capt=%h mism=%b busy=0",
                 capt8, mism8, busy8, e.capt, e.mism);
      end
    end
  endtask
  task automatic finish8();
    int ed;
    wait_done8(ed);
    @(negedge CLK);
  endtask
  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    start8 = 1'b1; start2 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0; start2 = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    total++;
    if ({test8, si8, busy8, done8, capt8, mism8} !== 12'h0 ||
        {test2, si2, busy2, done2, capt2, mism2} !== 6'h0) begin
      bad++;
      $display("FAIL reset_vals: dut8=%b_%b_%b_%b_%h_%b dut2=%b_%b_%b_%b_%b_%b want all 0",
               test8, si8, busy8, done8, capt8, mism8, test2, si2, busy2, done2, capt2, mism2);
    end
    @(negedge CLK);
    total++;
    if (busy8 !== 1'b0 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: busy8=%b busy2=%b want 0 0", busy8, busy2);
    end
  endtask
  task automatic test_hold();
    logic [7:0] p;
    int ed;
    p = 8'hA5; j8 = '0; k8 = '0;
    start_8(p, 8'hA5, 8'hFF);
    total++;
    if (busy8 !== 1'b1) begin
      bad++;
      $display("FAIL hold_busy: busy=%b want 1", busy8);
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (test8 !== 1'b1 || si8 !== p[7-k]) begin
        bad++;
        $display("FAIL hold_load%0d: test=%b scanin=%b want 1 %b", k, test8, si8, p[7-k]);
      end
      @(negedge CLK);
    end
    total++;
    if (test8 !== 1'b0 || si8 !== 1'b0) begin
      bad++;
      $display("FAIL hold_capture: test=%b scanin=%b want 0 0", test8, si8);
    end
    wait_done8(ed);
    total++;
    if (8 + ed != 17) begin
      bad++;
      $display("FAIL hold_latency: done at edge %0d want 17", 8 + ed);
    end
    @(negedge CLK);
  endtask
  task automatic test_toggle();
    j8 = 8'hFF; k8 = 8'hFF;
    start_8(8'h0F, 8'hF0, 8'hFF); finish8();
    start_8(8'h0F, 8'hF1, 8'h01); finish8();
    start_8(8'h0F, 8'hF1, 8'hF0); finish8();
    j8 = 8'h0F; k8 = 8'h3C;
    start_8(8'h55, 8'h00, 8'hFF); finish8();
  endtask
  task automatic test_back_to_back();
    int ed;
    j8 = '0; k8 = '0;
    start_8(8'h5A, 8'h5A, 8'hFF);
    repeat (3) @(negedge CLK);
    pat8 = 8'hFF; start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    wait_done8(ed);
    pat8 = 8'h00; start8 = 1'b1;
    @(negedge CLK);
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_start: busy=%b want 0", busy8);
    end
    start_8(8'h3C, 8'h3D, 8'h01);
    total++;
    if (busy8 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b want 1", busy8);
    end
    finish8();
  endtask
  task automatic test_reset_mid();
    logic seen;
    j8 = '0; k8 = '0;
    start_8(8'hC3, 8'hC3, 8'hFF);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    sbq.delete();
    total++;
    if (test8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 || si8 !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_vals: test=%b busy=%b done=%b scanin=%b want 0 0 0 0",
               test8, busy8, done8, si8);
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      seen = seen | done8 | busy8;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet: done/busy=%b want 0", seen);
    end
    start_8(8'h96, 8'h96, 8'hFF);
    finish8();
  endtask
  task automatic test_n2();
    exp_t e;
    int ed;
    j2 = '0; k2 = '0;
    pat2 = 2'b10; exp2 = 2'b10; mask2 = 2'b11; start2 = 1'b1;
    sbq.push_back('{capt: 8'h02, mism: 1'b0});
    @(negedge CLK);
    start2 = 1'b0;
    total++;
    if (test2 !== 1'b1 || si2 !== 1'b1) begin
      bad++;
      $display("FAIL n2_load0: test=%b scanin=%b want 1 1", test2, si2);
    end
    @(negedge CLK);
    total++;
    if (test2 !== 1'b1 || si2 !== 1'b0) begin
      bad++;
      $display("FAIL n2_load1: test=%b scanin=%b want 1 0", test2, si2);
    end
    @(negedge CLK);
    total++;
    if (test2 !== 1'b0) begin
      bad++;
      $display("FAIL n2_capture: test=%b want 0", test2);
    end
    ed = 0;
    while (!done2 && ed < 50) begin
      @(negedge CLK);
      ed++;
    end
    total++;
    e = sbq.pop_front();
    if (!done2 || 2 + ed != 5 || capt2 !== e.capt[1:0] || mism2 !== e.mism) begin
      bad++;
      $display("FAIL n2_result: done=%b edge=%0d capt=%b mism=%b want 1 5 %b %b",
               done2, 2 + ed, capt2, mism2, e.capt[1:0], e.mism);
    end
    @(negedge CLK);
  endtask
  initial begin
    test_reset();
    test_hold();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    test_n2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
